m_shiftcounter_p: RTL and testbench
===================================

Name: m_shiftcounter_p

Overview:
Parametrised successor to the midgetv shift counter. It is a CW-bit down counter that microcode uses to sequence multi-cycle shifts and other iterated operations. It adds synchronous reset, a configurable scaled-load mode, registered zero-load detection and a busy flag, so the microcode can skip zero-length shifts and test for completion without extra microcode states. It sits beside the ALU and is driven directly from two microcode control bits.

Parameters:
CW, 5, counter width in bits; legal range 2..8.
SCALE, 3, left-shift applied to ld[1:0] in scaled-load mode (5-bit default gives a byte-position shift count); legal range 0..CW-2.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
op  input  2  operation code: 00 load, 01 scaled load, 10 count down, 11 hold.
ld  input  CW  load value; for a shift, the low bits of the ALU B operand.
lastshift  output  1  combinational; high in a count-down cycle that consumes the final iteration.
rlastshift  output  1  lastshift registered; one cycle later.
r_issh0  output  1  registered; high after a load whose loaded value was zero.
busy  output  1  registered; high while iterations remain.
cnt  output  CW  current counter value.
cyone  output  1  constant 1'b1, used as a carry-chain source for the ALU.

Behaviour:
- Reset: on a rising edge with rst=1, cnt=0, rlastshift=0, r_issh0=0, busy=0. rst overrides op in that cycle. Reset mid-count abandons the count with no lastshift pulse registered.
- Load value for op=00: loadval = ld.
- Load value for op=01: loadval = {ld[1:0], SCALE zeros}, truncated or zero-extended to CW bits.
- Load (op=00 or 01), next cycle:
  - cnt=loadval.
  - r_issh0=(loadval==0).
  - busy=(loadval!=0).
  - lastshift=0 in the load cycle.
- Count down (op=10):
  - cnt decrements by 1 and wraps from 0 to all-ones.
  - lastshift = (cnt==0). The count therefore runs loadval+1 count-down cycles before lastshift, matching the microcode loop convention.
  - busy clears on the edge where lastshift=1 and is otherwise unchanged.
  - r_issh0 holds.
- Hold (op=11): cnt, busy and r_issh0 hold; lastshift=0.
- rlastshift updates every non-reset cycle: rlastshift <= lastshift.
- lastshift is the only combinational output. Its path is cnt==0 AND op==10, with no dependence on ld.
- Arithmetic: pure modulo-2^CW. No saturation, no overflow flag.
- Count down while busy=0 (after a completed or zero-length count) is legal. It wraps as above and may pulse lastshift again; the microcode is responsible for avoiding this.
- cyone is tied high; no sequential behaviour.
- Size target: CW+6 SB_LUT4 plus CW+3 SB_DFF at the default parameters.

Test Plan:
1. Reset check. Assert rst for 2 cycles with op=10, ld=5'h1F → cnt=0, busy=0, r_issh0=0, rlastshift=0. lastshift=1 is permitted while rst=1, but no state is registered from it.
2. Basic count. Load op=00, ld=3, then op=10 repeatedly.
   - cnt sequence: 3,2,1,0,31.
   - lastshift high only in the 4th count cycle (cnt=0).
   - rlastshift high the following cycle.
   - busy falls on that edge.
3. Scaled load. op=01, ld=5'b00010 with CW=5, SCALE=3 → cnt=16, r_issh0=0, busy=1. Then with ld[1:0]=00 → cnt=0, r_issh0=1, busy=0.
4. Hold and reset mid-count.
   - Load 5, count 2 cycles, then op=11 for 3 cycles → cnt stays 3, lastshift=0.
   - Assert rst with op=10 → cnt=0, busy=0, and no rlastshift pulse.
5. Parameter sweep. CW=8, SCALE=6; load ld=8'hFF, count 256 cycles → lastshift exactly once on the 256th count cycle; cnt wraps to 8'hFF. Repeat with CW=2, SCALE=0.
6. Back-to-back reload. Load 1, count once (cnt=0), then load 2 in the very next cycle → no lastshift, cnt=2, busy=1, r_issh0=0.

Source files
------------

// File: rtl/m_shiftcounter_p.sv
// CW-bit down counter that sequences multi-cycle shifts and other iterated
// microcode operations, with scaled load, zero-load detection and a busy flag.
module m_shiftcounter_p #(
  parameter int CW    = 5,
  parameter int SCALE = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    op,
  input  logic [CW-1:0] ld,
  output logic          lastshift,
  output logic          rlastshift,
  output logic          r_issh0,
  output logic          busy,
  output logic [CW-1:0] cnt,
  output logic          cyone
);

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_SLOAD = 2'b01,
    OP_COUNT = 2'b10,
    OP_HOLD  = 2'b11
  } op_e;

  if (CW < 2 || CW > 8) begin : g_bad_cw
    $error("m_shiftcounter_p: CW must lie in 2..8");
  end
  if (SCALE < 0 || SCALE > CW - 2) begin : g_bad_scale
    $error("m_shiftcounter_p: SCALE must lie in 0..CW-2");
  end

  op_e           op_t;
  logic [CW-1:0] scaled_val;
  logic [CW-1:0] load_val;

  assign op_t  = op_e'(op);
  assign cyone = 1'b1;

  // Scaled load places ld[1:0] at bit SCALE; SCALE <= CW-2 keeps it in range.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    scaled_val = CW'(ld[1:0]) << SCALE;
    load_val   = (op_t == OP_SLOAD) ? scaled_val : ld;
  end

  // Deliberately independent of ld and rst: only cnt and op feed this path.
  assign lastshift = (op_t == OP_COUNT) && (cnt == '0);

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      cnt        <= '0;
      rlastshift <= 1'b0;
      r_issh0    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rlastshift <= lastshift;
      unique case (op_t)
        OP_LOAD, OP_SLOAD: begin
          cnt     <= load_val;
          r_issh0 <= (load_val == '0);
          busy    <= (load_val != '0);
        end
        OP_COUNT: begin
          cnt <= cnt - CW'(1);
          if (lastshift) busy <= 1'b0;
        end
        OP_HOLD: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m_shiftcounter_p.sv
// Scoreboard bench for m_shiftcounter_p: directed vectors push expected state,
// a negedge monitor pops and compares against the selected instance.
module tb_m_shiftcounter_p;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] op;
  logic [7:0] ld8;

  logic       ls5, rls5, is5, busy5, cy5;
  logic [4:0] cnt5;
  logic       ls8, rls8, is8, busy8, cy8;
  logic [7:0] cnt8;
  logic       ls2, rls2, is2, busy2, cy2;
  logic [1:0] cnt2;

  always #5 clk = ~clk;

  m_shiftcounter_p #(.CW(5), .SCALE(3)) dut5 (
    .clk(clk), .rst(rst), .op(op), .ld(ld8[4:0]),
    .lastshift(ls5), .rlastshift(rls5), .r_issh0(is5), .busy(busy5),
    .cnt(cnt5), .cyone(cy5));

  m_shiftcounter_p #(.CW(8), .SCALE(6)) dut8 (
    .clk(clk), .rst(rst), .op(op), .ld(ld8),
    .lastshift(ls8), .rlastshift(rls8), .r_issh0(is8), .busy(busy8),
    .cnt(cnt8), .cyone(cy8));

  m_shiftcounter_p #(.CW(2), .SCALE(0)) dut2 (
    .clk(clk), .rst(rst), .op(op), .ld(ld8[1:0]),
    .lastshift(ls2), .rlastshift(rls2), .r_issh0(is2), .busy(busy2),
    .cnt(cnt2), .cyone(cy2));

  typedef struct {
    int         sel;     // 0: CW=5, 1: CW=8, 2: CW=2
    string      tag;
    logic [7:0] cnt;
    logic       busy;
    logic       issh0;
    logic       rls;
    logic       ls;
    logic       ls_dc;   // lastshift value not required this cycle
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Monitor: outputs are stable at the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t       e;
      logic [7:0] a_cnt;
      logic       a_busy, a_is, a_rls, a_ls, a_cy;
      e = exp_q.pop_front();
      case (e.sel)
        0:       begin a_cnt = {3'b0, cnt5}; a_busy = busy5; a_is = is5; a_rls = rls5; a_ls = ls5; a_cy = cy5; end
        1:       begin a_cnt = cnt8;         a_busy = busy8; a_is = is8; a_rls = rls8; a_ls = ls8; a_cy = cy8; end
        default: begin a_cnt = {6'b0, cnt2}; a_busy = busy2; a_is = is2; a_rls = rls2; a_ls = ls2; a_cy = cy2; end
      endcase
      check({e.tag, ".cnt"},        a_cnt,        e.cnt);
      check({e.tag, ".busy"},       {7'b0, a_busy}, {7'b0, e.busy});
      check({e.tag, ".r_issh0"},    {7'b0, a_is},   {7'b0, e.issh0});
      check({e.tag, ".rlastshift"}, {7'b0, a_rls},  {7'b0, e.rls});
      check({e.tag, ".cyone"},      {7'b0, a_cy},   8'h01);
      if (!e.ls_dc) check({e.tag, ".lastshift"}, {7'b0, a_ls}, {7'b0, e.ls});
    end
  end

  // Drive one cycle of inputs and, when chk is set, push the state expected
  // to be visible during that cycle (i.e. before its rising edge).
  task automatic step(input bit chk, input int sel, input string tag,
                      input logic r, input logic [1:0] o, input logic [7:0] l,
                      input logic [7:0] e_cnt, input logic e_busy, input logic e_is,
                      input logic e_rls, input logic e_ls, input logic e_ls_dc);
    exp_t e;
    rst = r;
    op  = o;
    ld8 = l;
    if (chk) begin
      e.sel = sel; e.tag = tag; e.cnt = e_cnt; e.busy = e_busy; e.issh0 = e_is;
      e.rls = e_rls; e.ls = e_ls; e.ls_dc = e_ls_dc;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1. reset with op=count and ld all ones
    step(0, 0, "rst0",  1, 2'b10, 8'h1F, 8'h00, 0, 0, 0, 0, 1);
    step(1, 0, "rst1",  1, 2'b10, 8'h1F, 8'h00, 0, 0, 0, 0, 1);

    // 2. load 3 then count through zero and wrap
    step(1, 0, "ld3",   0, 2'b00, 8'h03, 8'h00, 0, 0, 0, 0, 0);
    step(1, 0, "c1",    0, 2'b10, 8'h00, 8'h03, 1, 0, 0, 0, 0);
    step(1, 0, "c2",    0, 2'b10, 8'h00, 8'h02, 1, 0, 0, 0, 0);
    step(1, 0, "c3",    0, 2'b10, 8'h00, 8'h01, 1, 0, 0, 0, 0);
    step(1, 0, "c4",    0, 2'b10, 8'h00, 8'h00, 1, 0, 0, 1, 0);
    step(1, 0, "c5",    0, 2'b10, 8'h00, 8'h1F, 0, 0, 1, 0, 0);
    step(1, 0, "h0",    0, 2'b11, 8'h00, 8'h1E, 0, 0, 0, 0, 0);

    // 3. scaled loads: 2<<3=16, then ld[1:0]=0 with high bits set, then 3<<3=24
    step(1, 0, "sl2",   0, 2'b01, 8'h02, 8'h1E, 0, 0, 0, 0, 0);
    step(1, 0, "sl0",   0, 2'b01, 8'h1C, 8'h10, 1, 0, 0, 0, 0);
    step(1, 0, "h1",    0, 2'b11, 8'h00, 8'h00, 0, 1, 0, 0, 0);
    step(1, 0, "sl3",   0, 2'b01, 8'h03, 8'h00, 0, 1, 0, 0, 0);
    step(1, 0, "ld0",   0, 2'b00, 8'h00, 8'h18, 1, 0, 0, 0, 0);
    // count while idle at zero: wraps and pulses lastshift, r_issh0 holds
    step(1, 0, "idlec", 0, 2'b10, 8'h00, 8'h00, 0, 1, 0, 1, 0);

    // 4. hold mid-count, then reset mid-count
    step(1, 0, "ld5",   0, 2'b00, 8'h05, 8'h1F, 0, 1, 1, 0, 0);
    step(1, 0, "c5a",   0, 2'b10, 8'h00, 8'h05, 1, 0, 0, 0, 0);
    step(1, 0, "c5b",   0, 2'b10, 8'h00, 8'h04, 1, 0, 0, 0, 0);
    step(1, 0, "hld1",  0, 2'b11, 8'h00, 8'h03, 1, 0, 0, 0, 0);
    step(1, 0, "hld2",  0, 2'b11, 8'h00, 8'h03, 1, 0, 0, 0, 0);
    step(1, 0, "hld3",  0, 2'b11, 8'h00, 8'h03, 1, 0, 0, 0, 0);
    step(1, 0, "rstm",  1, 2'b10, 8'h00, 8'h03, 1, 0, 0, 0, 0);
    step(1, 0, "ld1",   0, 2'b00, 8'h01, 8'h00, 0, 0, 0, 0, 0);
    step(1, 0, "c1a",   0, 2'b10, 8'h00, 8'h01, 1, 0, 0, 0, 0);
    // reset exactly when lastshift would fire: no rlastshift afterwards
    step(1, 0, "rstz",  1, 2'b10, 8'h00, 8'h00, 1, 0, 0, 1, 1);
    step(1, 0, "postr", 0, 2'b11, 8'h00, 8'h00, 0, 0, 0, 0, 0);

    // 6. back-to-back reload right when cnt reaches zero
    step(1, 0, "bb_l1", 0, 2'b00, 8'h01, 8'h00, 0, 0, 0, 0, 0);
    step(1, 0, "bb_c",  0, 2'b10, 8'h00, 8'h01, 1, 0, 0, 0, 0);
    step(1, 0, "bb_l2", 0, 2'b00, 8'h02, 8'h00, 1, 0, 0, 0, 0);
    step(1, 0, "bb_h",  0, 2'b11, 8'h00, 8'h02, 1, 0, 0, 0, 0);

    // 5a. CW=8, SCALE=6: 256 count cycles from 8'hFF
    step(0, 1, "r8",    1, 2'b11, 8'h00, 8'h00, 0, 0, 0, 0, 0);
    step(1, 1, "w8_ld", 0, 2'b00, 8'hFF, 8'h00, 0, 0, 0, 0, 0);
    for (int i = 0; i < 256; i++) begin
      step(1, 1, $sformatf("w8_c%0d", i), 0, 2'b10, 8'h00,
           8'(255 - i), 1, 0, 0, (i == 255), 0);
    end
    step(1, 1, "w8_h",  0, 2'b11, 8'h00, 8'hFF, 0, 0, 1, 0, 0);
    step(1, 1, "w8_sl", 0, 2'b01, 8'h03, 8'hFF, 0, 0, 0, 0, 0);
    step(1, 1, "w8_h2", 0, 2'b11, 8'h00, 8'hC0, 1, 0, 0, 0, 0);

    // 5b. CW=2, SCALE=0: 4 count cycles from 3
    step(0, 2, "r2",    1, 2'b11, 8'h00, 8'h00, 0, 0, 0, 0, 0);
    step(1, 2, "w2_ld", 0, 2'b00, 8'h03, 8'h00, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 2, $sformatf("w2_c%0d", i), 0, 2'b10, 8'h00,
           8'(3 - i), 1, 0, 0, (i == 3), 0);
    end
    step(1, 2, "w2_h",  0, 2'b11, 8'h00, 8'h03, 0, 0, 1, 0, 0);
    step(1, 2, "w2_sl", 0, 2'b01, 8'h02, 8'h03, 0, 0, 0, 0, 0);
    step(1, 2, "w2_h2", 0, 2'b11, 8'h00, 8'h02, 1, 0, 0, 0, 0);

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
